// File: rtl/dac_buf_pkg.sv
// Shared widths for the DAC sample buffer: byte write port, 32-bit word read port.
package dac_buf_pkg;

  localparam int unsigned A_AW     = 11;
  localparam int unsigned B_AW     = A_AW - 2;
  localparam int unsigned DW       = 8;
  localparam int unsigned NumLanes = 4;
  // Low byte-address bits that pick the lane inside a word.
  localparam int unsigned LaneSelW = $clog2(NumLanes);

endpackage

// File: rtl/dac_buf_lane.sv
// One byte lane of the DAC buffer: simple dual-port RAM with a read-first,
// registered, synchronously resettable output, written to infer block RAM.
module dac_buf_lane #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  // Power-up contents are zero; nothing ever clears the array afterwards.
  logic [DW-1:0] mem_q [Depth] = '{default: '0};
  logic [DW-1:0] rdata_q;

  // Writes are independent of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dac_buf_ram.sv
// DAC sample buffer: 2048-byte write port, 512x32 little-endian read port.
// Four byte lanes; the top only decodes the lane and packs lane 3..0 outputs.
module dac_buf_ram #(
  parameter int unsigned A_AW = dac_buf_pkg::A_AW,
  parameter int unsigned B_AW = dac_buf_pkg::B_AW,
  parameter int unsigned DW   = dac_buf_pkg::DW
) (
  input  logic            clkin,
  input  logic            reset,
  input  logic            wea,
  input  logic [A_AW-1:0] addra,
  input  logic [DW-1:0]   dina,
  input  logic [B_AW-1:0] addrb,
  output logic [4*DW-1:0] doutb
);

  import dac_buf_pkg::*;

  logic [NumLanes-1:0] lane_we;
  logic [DW-1:0]       lane_rdata [NumLanes];

  for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
    assign lane_we[i] = wea && (addra[LaneSelW-1:0] == LaneSelW'(i));

    dac_buf_lane #(
      .AW(B_AW),
      .DW(DW)
    ) u_lane (
      .clk_i  (clkin),
      .rst_i  (reset),
      .we_i   (lane_we[i]),
      .waddr_i(addra[A_AW-1:LaneSelW]),
      .wdata_i(dina),
      .raddr_i(addrb),
      .rdata_o(lane_rdata[i])
    );

    // Byte 4w lands in the least significant lane of the word.
    assign doutb[i*DW +: DW] = lane_rdata[i];
  end

endmodule

// File: tb/tb_dac_buf_ram.sv
// Bench for dac_buf_ram: directed vector table, write-disabled sweep, random stream vs byte model.
module tb_dac_buf_ram;

  logic        clkin = 1'b0;
  logic        reset;
  logic        wea;
  logic [10:0] addra;
  logic [7:0]  dina;
  logic [8:0]  addrb;
  logic [31:0] doutb;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: plain byte array, zero at power-up.
  logic [7:0] model_mem [2048];

  always #5 clkin = ~clkin;

  dac_buf_ram dut (
    .clkin(clkin),
    .reset(reset),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .addrb(addrb),
    .doutb(doutb)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [10:0] a;
    logic [7:0]  d;
    logic [8:0]  b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model_word(input logic [8:0] w);
    int base;
    base = int'(w) * 4;
    return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: doutb=%08h expected %08h", name, got, exp);
    end
  endtask

  // Drive one cycle; returns the model's expectation for doutb after the edge.
  task automatic step(input logic rst, input logic we, input logic [10:0] a,
                      input logic [7:0] d, input logic [8:0] b, output logic [31:0] exp);
    @(negedge clkin);
    reset = rst;
    wea   = we;
    addra = a;
    dina  = d;
    addrb = b;
    exp = rst ? 32'h0 : model_word(b);
    if (we) model_mem[a] = d;
    @(posedge clkin);
    #1;
  endtask

  vec_t vecs [18];

  initial begin
    logic [31:0] exp;
    logic [10:0] ra;
    logic [8:0]  rb;
    logic        rw;
    logic        rr;

    for (int i = 0; i < 2048; i++) model_mem[i] = 8'h00;
    reset = 1'b1;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    addrb = '0;

    vecs[0]  = '{1'b1, 1'b0, 11'd0,    8'h00, 9'd0,   32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 11'd0,    8'h11, 9'd0,   32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 11'd1,    8'h22, 9'd0,   32'h0000_0011};
    vecs[3]  = '{1'b0, 1'b1, 11'd2,    8'h33, 9'd0,   32'h0000_2211};
    vecs[4]  = '{1'b0, 1'b1, 11'd3,    8'h44, 9'd0,   32'h0033_2211};
    vecs[5]  = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd0,   32'h4433_2211};
    vecs[6]  = '{1'b0, 1'b1, 11'd2047, 8'hAB, 9'd511, 32'h0000_0000};
    vecs[7]  = '{1'b0, 1'b1, 11'd2044, 8'hCD, 9'd511, 32'hAB00_0000};
    vecs[8]  = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd511, 32'hAB00_00CD};
    vecs[9]  = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd0,   32'h4433_2211};
    vecs[10] = '{1'b0, 1'b1, 11'd20,   8'h7F, 9'd5,   32'h0000_0000};
    vecs[11] = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd5,   32'h0000_007F};
    vecs[12] = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd0,   32'h4433_2211};
    vecs[13] = '{1'b1, 1'b1, 11'd1,    8'h55, 9'd0,   32'h0000_0000};
    vecs[14] = '{1'b1, 1'b0, 11'd0,    8'h00, 9'd0,   32'h0000_0000};
    vecs[15] = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd0,   32'h4433_5511};
    vecs[16] = '{1'b0, 1'b1, 11'd8,    8'h99, 9'd0,   32'h4433_5511};
    vecs[17] = '{1'b0, 1'b0, 11'd0,    8'h00, 9'd2,   32'h0000_0099};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].b, exp);
      check($sformatf("vec%0d", i), doutb, vecs[i].exp);
    end

    // Write-disabled sweep must leave every word intact.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 11'($urandom), 8'($urandom), 9'($urandom), exp);
    end
    for (int w = 0; w < 512; w++) begin
      step(1'b0, 1'b0, 11'($urandom), 8'($urandom), 9'(w), exp);
      check($sformatf("sweep_w%0d", w), doutb, exp);
    end

    // Random stream with frequent same-word collisions and occasional reset.
    for (int i = 0; i < 10000; i++) begin
      ra = 11'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra[10:2] : 9'($urandom);
      rw = 1'($urandom);
      rr = ($urandom_range(0, 63) == 0);
      step(rr, rw, ra, 8'($urandom), rb, exp);
      check($sformatf("rand%0d", i), doutb, exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_buf_ram.md
DAC_BUF_RAM -- requirements
Module: dac_buf_ram

Interface
REQ-001 SHALL have parameter A_AW, default 11, meaning the byte write-port address width.
REQ-002 SHALL have parameter B_AW, default 9, meaning the word read-port address width, fixed at A_AW-2.
REQ-003 SHALL have parameter DW, default 8, meaning the write byte width; the read word width SHALL be 4*DW.
REQ-004 SHALL have port clkin, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port wea, input, 1 bit: byte write enable, active high.
REQ-007 SHALL have port addra, input, A_AW bits: byte write address (0..2047).
REQ-008 SHALL have port dina, input, DW bits: write data byte.
REQ-009 SHALL have port addrb, input, B_AW bits: word read address (0..511).
REQ-010 SHALL have port doutb, output, 4*DW bits: registered read word.

Function
REQ-011 Storage SHALL be 2048 bytes, viewed as 512 words of 32 bits.
REQ-012 Byte mapping SHALL be little-endian: word w = {byte 4w+3, byte 4w+2, byte 4w+1, byte 4w}, so byte 4w drives doutb[7:0].
REQ-013 Lane mapping consequence: doutb[15:0] is sample A = {byte1, byte0} and doutb[31:16] is sample B = {byte3, byte2}, each 16-bit two's complement.
REQ-014 When wea=1 at a clock edge, dina SHALL be stored at byte address addra, into lane addra[1:0] of word addra[10:2]; the other three lanes SHALL be unchanged.
REQ-015 When wea=0, memory SHALL NOT change.
REQ-016 Reads SHALL occur every cycle without an enable: doutb SHALL equal word[addrb sampled at edge N] after edge N, a latency of 1 cycle.
REQ-017 Read-during-write to the same word SHALL be read-first: doutb returns the pre-write contents, and the new byte is visible from the next read.
REQ-018 Writes to a different word than the one being read SHALL NOT affect doutb in that cycle.
REQ-019 Address wrap SHALL NOT occur: all 11-bit and 9-bit values are valid, and no out-of-range case exists.
REQ-020 Memory contents SHALL be all zero after configuration/power-up; no clear operation exists.

Reset
REQ-021 While reset=1 at an edge, doutb SHALL be set to 0 and SHALL hold at 0 for every reset cycle.
REQ-022 Reset SHALL NOT clear or alter memory contents.
REQ-023 Writes with wea=1 during reset SHALL still be performed.
REQ-024 On the first edge with reset=0, doutb SHALL load word[addrb] normally.
REQ-025 Reset asserted mid-stream SHALL only force doutb to 0, with no other side effects.

Structure
REQ-026 Package dac_buf_pkg SHALL hold A_AW, B_AW, DW, the lane count (4) and the lane-index helper constant; the package holds no typedefs beyond these widths.
REQ-027 SHALL instantiate four sub-module instances of dac_buf_lane.
REQ-028 Each dac_buf_lane SHALL be a 512x8 simple dual-port RAM with a write enable and a registered, synchronously resettable read output, inferable as block RAM.
REQ-029 Lane i write enable SHALL be wea & (addra[1:0]==i); the lane write address SHALL be addra[10:2].
REQ-030 The top level SHALL only decode lanes and concatenate lane outputs 3..0 into doutb.

Verification
REQ-031 Write bytes 0x11,0x22,0x33,0x44 to addra 0..3, then set addrb=0 -> doutb=0x44332211 one cycle later.
REQ-032 Write 0xAB to addra 2047 and 0xCD to addra 2044, then read addrb=511 -> doutb=0xAB0000CD; addrb=0 still returns 0x44332211.
REQ-033 Word 5 holds 0x00000000; in the same cycle set addrb=5 and write 0x7F to addra 20 -> doutb=0x00000000 (read-first); next cycle -> 0x0000007F.
REQ-034 Read addrb=0 (0x44332211), then assert reset for 2 cycles -> doutb=0 during reset; a write of 0x55 to addra 1 during reset persists; after reset, addrb=0 -> 0x44335511.
REQ-035 Hold wea=0 while sweeping addra and dina over random values -> all 512 words read back unchanged versus a reference model.
REQ-036 Stream random wea/addra/dina/addrb for 10k cycles -> doutb matches a byte-array model with 1-cycle latency, read-first, and little-endian packing.
